// File: rtl/bus_dev_endpoint.sv
// Device-side bus endpoint: TX FIFO drained by the bus, address-filtered RX FIFO
// read by the device, saturating drop/overflow counters and a sticky error flag.
module bus_dev_endpoint #(
    parameter int unsigned pckg_sz   = 32,
    parameter int unsigned DEPTH     = 8,
    parameter logic [7:0]  ID        = 8'd0,
    parameter logic [7:0]  broadcast = 8'hFF,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    input  logic               rx_rd,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_empty,
    output logic [CNT_W-1:0]   rx_drop_cnt,
    output logic [CNT_W-1:0]   rx_ovf_cnt,
    output logic               err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [pckg_sz-1:0] tx_mem [DEPTH];
    logic [pckg_sz-1:0] rx_mem [DEPTH];
    logic [AW-1:0]      tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [CW-1:0]      tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [CNT_W-1:0]   drop_q, ovf_q;
    logic               err_q, err_d;

    logic               tx_pop_ok, tx_wr_ok, rx_pop_ok, rx_wr_ok;
    logic               rx_acc, rx_drop, rx_ovf;
    logic [7:0]         dst;

    // Qualify every request against current occupancy and derive next counts/error
    always_comb begin
        dst       = D_push[pckg_sz-1 -: 8];
        tx_pop_ok = pop && (tx_cnt_q != '0);
        // a pop in the same cycle frees the slot, so a write to a full FIFO still lands
        tx_wr_ok  = tx_wr && ((tx_cnt_q != FULL_CNT) || tx_pop_ok);
        rx_acc    = push && ((dst == ID) || (dst == broadcast));
        rx_drop   = push && !rx_acc;
        rx_pop_ok = rx_rd && (rx_cnt_q != '0);
        rx_wr_ok  = rx_acc && ((rx_cnt_q != FULL_CNT) || rx_pop_ok);
        rx_ovf    = rx_acc && !rx_wr_ok;
        tx_cnt_d  = tx_cnt_q + CW'(tx_wr_ok) - CW'(tx_pop_ok);
        rx_cnt_d  = rx_cnt_q + CW'(rx_wr_ok) - CW'(rx_pop_ok);
        err_d     = err_q
                  | (pop && (tx_cnt_q == '0))
                  | (tx_wr && !tx_wr_ok)
                  | (rx_rd && (rx_cnt_q == '0));
    end

    // Pointers, occupancy, counters and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
            drop_q   <= '0;
            ovf_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (tx_wr_ok)  tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop_ok) tx_rp_q <= tx_rp_q + 1'b1;
            if (rx_wr_ok)  rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop_ok) rx_rp_q <= rx_rp_q + 1'b1;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            if (rx_drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
            if (rx_ovf && (ovf_q != '1))   ovf_q  <= ovf_q + 1'b1;
            err_q <= err_d;
        end
    end

    // Storage arrays; contents are never observed unless occupancy covers them
    always_ff @(posedge clk) begin
        if (tx_wr_ok) tx_mem[tx_wp_q] <= tx_data;
        if (rx_wr_ok) rx_mem[rx_wp_q] <= D_push;
    end

    // Zero-latency head views, forced to zero when the FIFO is empty
    always_comb begin
        pndng       = (tx_cnt_q != '0);
        tx_full     = (tx_cnt_q == FULL_CNT);
        rx_empty    = (rx_cnt_q == '0);
        D_pop       = pndng ? tx_mem[tx_rp_q] : '0;
        rx_data     = rx_empty ? '0 : rx_mem[rx_rp_q];
        rx_drop_cnt = drop_q;
        rx_ovf_cnt  = ovf_q;
        err         = err_q;
    end

endmodule

// File: tb/tb_bus_dev_endpoint.sv
// Bench for bus_dev_endpoint: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_bus_dev_endpoint;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pop = 0, push = 0, tx_wr = 0, rx_rd = 0;
    logic [31:0] D_push = '0, tx_data = '0;
    logic        pndng, tx_full, rx_empty, err;
    logic [31:0] D_pop, rx_data;
    logic [15:0] rx_drop_cnt, rx_ovf_cnt;

    // second instance for counter saturation with a narrow counter
    logic        pop2 = 0, push2 = 0, tx_wr2 = 0, rx_rd2 = 0;
    logic [31:0] D_push2 = '0, tx_data2 = '0;
    logic        pndng2, tx_full2, rx_empty2, err2;
    logic [31:0] D_pop2, rx_data2;
    logic [3:0]  drop2, ovf2;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    int          m_drop = 0, m_ovf = 0;
    bit          m_err = 0;

    always #5 clk = ~clk;

    bus_dev_endpoint #(.pckg_sz(32), .DEPTH(DEPTH), .ID(8'h03), .broadcast(8'hFF), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
        .D_push(D_push), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .rx_rd(rx_rd),
        .rx_data(rx_data), .rx_empty(rx_empty), .rx_drop_cnt(rx_drop_cnt),
        .rx_ovf_cnt(rx_ovf_cnt), .err(err)
    );

    bus_dev_endpoint #(.pckg_sz(32), .DEPTH(4), .ID(8'h00), .broadcast(8'hFF), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .pndng(pndng2), .D_pop(D_pop2), .pop(pop2), .push(push2),
        .D_push(D_push2), .tx_wr(tx_wr2), .tx_data(tx_data2), .tx_full(tx_full2), .rx_rd(rx_rd2),
        .rx_data(rx_data2), .rx_empty(rx_empty2), .rx_drop_cnt(drop2),
        .rx_ovf_cnt(ovf2), .err(err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pndng"},    {31'd0, pndng},    {31'd0, tx_q.size() != 0});
        chk({tag, ".D_pop"},    D_pop,             (tx_q.size() != 0) ? tx_q[0] : 32'd0);
        chk({tag, ".tx_full"},  {31'd0, tx_full},  {31'd0, tx_q.size() == DEPTH});
        chk({tag, ".rx_empty"}, {31'd0, rx_empty}, {31'd0, rx_q.size() == 0});
        chk({tag, ".rx_data"},  rx_data,           (rx_q.size() != 0) ? rx_q[0] : 32'd0);
        chk({tag, ".drop"},     {16'd0, rx_drop_cnt}, 32'(m_drop));
        chk({tag, ".ovf"},      {16'd0, rx_ovf_cnt},  32'(m_ovf));
        chk({tag, ".err"},      {31'd0, err},      {31'd0, m_err});
    endtask

    function automatic void model_reset();
        tx_q.delete();
        rx_q.delete();
        m_drop = 0;
        m_ovf  = 0;
        m_err  = 0;
    endfunction

    // one bus cycle as the rules describe it, applied to the queues
    function automatic void model_cycle();
        bit tpop, twr, acc, rpop;
        tpop = pop && tx_q.size() > 0;
        twr  = tx_wr && (tx_q.size() < DEPTH || tpop);
        if (pop && tx_q.size() == 0) m_err = 1;
        if (tx_wr && !twr) m_err = 1;
        if (tpop) void'(tx_q.pop_front());
        if (twr) tx_q.push_back(tx_data);

        acc  = push && (D_push[31:24] == 8'h03 || D_push[31:24] == 8'hFF);
        rpop = rx_rd && rx_q.size() > 0;
        if (rx_rd && rx_q.size() == 0) m_err = 1;
        if (push && !acc && m_drop < 65535) m_drop++;
        if (acc && !(rx_q.size() < DEPTH || rpop) && m_ovf < 65535) m_ovf++;
        if (acc && (rx_q.size() < DEPTH || rpop)) begin
            if (rpop) void'(rx_q.pop_front());
            rx_q.push_back(D_push);
        end else if (rpop) begin
            void'(rx_q.pop_front());
        end
    endfunction

    // drive one cycle: inputs held across the edge, then model update and full check
    task automatic cyc(input string tag, input bit w, input logic [31:0] wd, input bit p,
                       input bit ps, input logic [31:0] pd, input bit r);
        tx_wr = w; tx_data = wd; pop = p; push = ps; D_push = pd; rx_rd = r;
        @(posedge clk);
        #1;
        model_cycle();
        tx_wr = 0; pop = 0; push = 0; rx_rd = 0;
        check_all(tag);
    endtask

    initial begin
        // power-on reset
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check_all("reset_state");

        // reset mid-traffic, with RX counters made nonzero first
        cyc("t1_wr0", 1, 32'h11110000, 0, 1, 32'h03000001, 0);
        cyc("t1_wr1", 1, 32'h11110001, 0, 1, 32'h07000002, 0);
        cyc("t1_wr2", 1, 32'h11110002, 0, 0, 32'h0, 0);
        chk("t1_pre_drop", {16'd0, rx_drop_cnt}, 32'd1);
        reset = 1'b1;
        #2;
        model_reset();
        check_all("t1_async_reset");
        #2;
        reset = 1'b0;

        // TX ordering through a full FIFO
        for (int i = 1; i <= 8; i++) cyc("t2_fill", 1, 32'hAA000000 + 32'(i), 0, 0, 32'h0, 0);
        chk("t2_full", {31'd0, tx_full}, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            chk("t2_head", D_pop, 32'hAA000000 + 32'(i));
            cyc("t2_pop", 0, 32'h0, 1, 0, 32'h0, 0);
        end
        chk("t2_pndng", {31'd0, pndng}, 32'd0);

        // simultaneous write and pop while full
        for (int i = 0; i < 8; i++) cyc("t3_fill", 1, 32'hBB000000 + 32'(i), 0, 0, 32'h0, 0);
        cyc("t3_both", 1, 32'hBB0000FF, 1, 0, 32'h0, 0);
        chk("t3_still_full", {31'd0, tx_full}, 32'd1);
        chk("t3_no_err", {31'd0, err}, 32'd0);
        for (int i = 0; i < 8; i++) cyc("t3_drain", 0, 32'h0, 1, 0, 32'h0, 0);

        // address filter
        cyc("t4_id",    0, 32'h0, 0, 1, 32'h03ABCDEF, 0);
        cyc("t4_bcast", 0, 32'h0, 0, 1, 32'hFF123456, 0);
        cyc("t4_other", 0, 32'h0, 0, 1, 32'h05FEDCBA, 0);
        chk("t4_drop", {16'd0, rx_drop_cnt}, 32'd1);
        chk("t4_head", rx_data, 32'h03ABCDEF);
        cyc("t4_rd0", 0, 32'h0, 0, 0, 32'h0, 1);
        cyc("t4_rd1", 0, 32'h0, 0, 0, 32'h0, 1);
        chk("t4_empty", {31'd0, rx_empty}, 32'd1);

        // RX overflow: ninth packet lost, first eight come back in order
        for (int i = 0; i < 9; i++) cyc("t5_push", 0, 32'h0, 0, 1, 32'h03000100 + 32'(i), 0);
        chk("t5_ovf", {16'd0, rx_ovf_cnt}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("t5_order", rx_data, 32'h03000100 + 32'(i));
            cyc("t5_rd", 0, 32'h0, 0, 0, 32'h0, 1);
        end
        // push and read together while full keeps it full
        for (int i = 0; i < 8; i++) cyc("t5_refill", 0, 32'h0, 0, 1, 32'hFF000200 + 32'(i), 0);
        cyc("t5_push_rd", 0, 32'h0, 0, 1, 32'h03000300, 1);
        chk("t5_ovf_same", {16'd0, rx_ovf_cnt}, 32'd1);
        for (int i = 0; i < 8; i++) cyc("t5_drain", 0, 32'h0, 0, 0, 32'h0, 1);

        // error stickiness
        chk("t6_err_clear", {31'd0, err}, 32'd0);
        cyc("t6_pop_empty", 0, 32'h0, 1, 0, 32'h0, 0);
        chk("t6_err_set", {31'd0, err}, 32'd1);
        repeat (3) cyc("t6_sticky", 0, 32'h0, 0, 0, 32'h0, 0);

        // narrow counter saturation
        for (int i = 1; i <= 20; i++) begin
            push2 = 1'b1;
            D_push2 = {8'h10, 24'($urandom)};
            @(posedge clk);
            #1;
            push2 = 1'b0;
            chk("t6_sat", {28'd0, drop2}, (i > 15) ? 32'd15 : 32'(i));
        end

        // random traffic on both paths
        for (int i = 0; i < 400; i++) begin
            logic [7:0]  d;
            logic [31:0] pd;
            case ($urandom_range(0, 2))
                0: d = 8'h03;
                1: d = 8'hFF;
                default: d = 8'($urandom);
            endcase
            pd = {d, 24'($urandom)};
            cyc("rand", ($urandom_range(0, 2) != 0), $urandom, ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 1) == 1), pd, ($urandom_range(0, 2) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
